// File: rtl/ccff_pkg.sv
// ccff_pkg: FSM encoding, chain marker bit and byte-count helper shared by the CCFF loader files.
package ccff_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE, ERR} ccff_state_e;
  localparam logic CCFF_MARKER = 1'b1;
  function automatic int ccff_num_bytes(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction
endpackage

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer: 8-bit MSB-first shift register with bit index and last-bit flag.
module ccff_byte_serializer (
  input  logic       prog_clk,
  input  logic       prog_rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] data,
  output logic       head,
  output logic       last
);
  logic [7:0] sreg_q, sreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  always_comb begin
    sreg_d = load ? data : shift ? {sreg_q[6:0], 1'b0} : sreg_q;
    bit_idx_d = load ? 3'd0 : shift ? bit_idx_q + 3'd1 : bit_idx_q;
  end
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      sreg_q <= '0;
      bit_idx_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end
  assign head = sreg_q[7];
  assign last = bit_idx_q == 3'd7;
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises a byte stream MSB-first into the CCFF chain, CHAIN_LEN pulses per load.
// Define CCFF_TAIL_CHECK_EN to prepend a marker bit and require it at ccff_tail on the last data pulse.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 29,
  parameter int CNT_W = 16
) (
  input  logic       prog_clk,
  input  logic       prog_rst_n,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       err
);
`ifdef CCFF_TAIL_CHECK_EN
  localparam logic TAIL_CHK = 1'b1;
`else
  localparam logic TAIL_CHK = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] NUM_BYTES = CNT_W'(ccff_num_bytes(CHAIN_LEN));
  ccff_state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
  logic mark_q, mark_d;
  logic load, ser_head, ser_last;
  ccff_byte_serializer u_ser (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .load      (load),
    .shift     (ccff_shift_en && !mark_q),
    .data      (byte_data),
    .head      (ser_head),
    .last      (ser_last)
  );
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    mark_d = mark_q;
    load = 1'b0;
    case (state_q)
      FETCH: if (byte_valid && byte_ready) begin
        load = 1'b1;
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
        state_d = SHIFT;
      end
      SHIFT: if (mark_q) begin
        mark_d = 1'b0;
        state_d = FETCH;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // a marker seen before the last pulse means a short chain; missing on it means a long or broken one
        if (bit_cnt_q == LAST_BIT) state_d = (!TAIL_CHK || ccff_tail) ? DONE : ERR;
        else if (TAIL_CHK && ccff_tail) state_d = ERR;
        else if (ser_last) state_d = FETCH;
      end
      default: if (start) begin
        state_d = TAIL_CHK ? SHIFT : FETCH;
        mark_d = TAIL_CHK;
        bit_cnt_d = '0;
        byte_cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      byte_cnt_q <= '0;
      mark_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      mark_q <= mark_d;
    end
  end
  assign ccff_shift_en = state_q == SHIFT;
  assign ccff_head = ccff_shift_en & (mark_q ? CCFF_MARKER : ser_head);
  assign byte_ready = state_q == FETCH && byte_cnt_q < NUM_BYTES;
  assign busy = state_q == FETCH || state_q == SHIFT;
  assign done = state_q == DONE;
  assign err = state_q == ERR;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: table-driven load scenarios plus reset-mid-load and tail-check sequences.
module tb_ccff_bitstream_loader;
  logic prog_clk, prog_rst_n, start, byte_valid, byte_ready;
  logic ccff_head, ccff_shift_en, ccff_tail, busy, done, err, clr;
  logic [7:0] byte_data;
  logic [7:0] stream [8];
  logic [63:0] heads, exp_heads;
  logic [31:0] chain, word;
  int pulses, acc, tail_len, checks, failures, gap_bad;
`ifdef CCFF_TAIL_CHECK_EN
  localparam int EXP_P = 30;
`else
  localparam int EXP_P = 29;
`endif
  typedef struct {
    int gap_after;
    int gap_len;
    int start_at;
    int exp_pulses;
    int exp_bytes;
  } vec_t;
  vec_t vecs [4];

  ccff_bitstream_loader dut (
    .prog_clk     (prog_clk),
    .prog_rst_n   (prog_rst_n),
    .start        (start),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 prog_clk = ~prog_clk;
  assign ccff_tail = chain[tail_len-1];
  assign byte_data = (acc < 8) ? stream[acc] : 8'h00;

  always @(posedge prog_clk) begin
    if (clr) begin
      pulses <= 0;
      acc <= 0;
      heads <= '0;
      chain <= '0;
    end else begin
      if (ccff_shift_en) begin
        pulses <= pulses + 1;
        heads <= {heads[62:0], ccff_head};
        chain <= {chain[30:0], ccff_head};
      end
      if (byte_valid && byte_ready) acc <= acc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic begin_load();
    clr = 1;
    byte_valid = 0;
    @(posedge prog_clk);
    #1 clr = 0;
    start = 1;
    @(posedge prog_clk);
    #1 start = 0;
    byte_valid = 1;
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!(done || err) && t < 600) begin
      @(negedge prog_clk);
      t++;
    end
    chk(name, t < 600, 1);
  endtask

  task automatic run_row(input vec_t v);
    int t;
    begin_load();
    gap_bad = 0;
    if (v.start_at > 0) begin
      t = 0;
      while (pulses < v.start_at && t < 200) begin
        @(negedge prog_clk);
        t++;
      end
      chk("mid_start_reach", t < 200, 1);
      start = 1;
      @(negedge prog_clk);
      start = 0;
    end
    if (v.gap_len > 0) begin
      t = 0;
      while (acc < v.gap_after && t < 200) begin
        @(negedge prog_clk);
        t++;
      end
      byte_valid = 0;
      while (!byte_ready && t < 400) begin
        @(negedge prog_clk);
        t++;
      end
      chk("gap_fetch_reach", t < 400, 1);
      repeat (v.gap_len) begin
        @(negedge prog_clk);
        if (ccff_shift_en || !byte_ready) gap_bad++;
      end
      byte_valid = 1;
    end
    wait_end("done_reach");
    repeat (10) @(negedge prog_clk);
    chk("pulses", pulses, v.exp_pulses);
    chk("heads", heads, exp_heads);
    chk("done", done, 1);
    chk("busy", busy, 0);
    chk("err", err, 0);
    chk("byte_ready_after", byte_ready, 0);
    chk("bytes_taken", acc, v.exp_bytes);
    chk("gap_hold", gap_bad, 0);
    byte_valid = 0;
  endtask

  initial begin
    int t;
    prog_clk = 0;
    prog_rst_n = 0;
    start = 0;
    byte_valid = 0;
    clr = 1;
    tail_len = 29;
    checks = 0;
    failures = 0;
    stream = '{8'hA5, 8'h3C, 8'hF0, 8'h81, 8'h55, 8'hAA, 8'h0F, 8'hFF};
    word = 32'hA53CF081;
`ifdef CCFF_TAIL_CHECK_EN
    exp_heads = {34'd0, 1'b1, word[31:3]};
`else
    exp_heads = {35'd0, word[31:3]};
`endif
    vecs[0] = '{0, 0, 0, EXP_P, 4};
    vecs[1] = '{2, 5, 0, EXP_P, 4};
    vecs[2] = '{0, 0, 5, EXP_P, 4};
    vecs[3] = '{1, 3, 3, EXP_P, 4};
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    prog_rst_n = 1;
    @(posedge prog_clk);
    #1;
    for (int i = 0; i < 4; i++) run_row(vecs[i]);
    begin_load();
    t = 0;
    while (pulses < 12 && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    chk("mid_rst_reach", t < 200, 1);
    chk("mid_rst_shifting", ccff_shift_en, 1);
    prog_rst_n = 0;
    #1;
    chk("mid_rst_shift_en", ccff_shift_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_head", ccff_head, 0);
    @(negedge prog_clk);
    byte_valid = 0;
    prog_rst_n = 1;
    run_row(vecs[0]);
`ifdef CCFF_TAIL_CHECK_EN
    tail_len = 28;
    begin_load();
    wait_end("short_chain_reach");
    repeat (3) @(negedge prog_clk);
    chk("short_err", err, 1);
    chk("short_done", done, 0);
    chk("short_busy", busy, 0);
    byte_valid = 0;
    start = 1;
    @(posedge prog_clk);
    #1 start = 0;
    @(negedge prog_clk);
    chk("restart_err", err, 0);
    chk("restart_busy", busy, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
